multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
// Main sequencing FSM for the multicycle RV32I core. Decodes op, steps each instruction through
// fetch/decode/execute/memory/writeback states, and drives all datapath enables and mux selects.
// Emits ALUOp[1:0] for the downstream ALU decoder (00 add, 01 sub, 10 use funct3/funct7).
// Supports lw, sw, R-type, I-type ALU, beq and jal; optional memory wait states.
// PARAMETERS
// MEM_WAIT_CYCLES  0  extra stall cycles added to FETCH, MEMREAD and MEMWRITE (0..15)
// PORTS
// clk           in   1  core clock, rising edge
// rst           in   1  asynchronous reset, active-high
// op            in   7  instr[6:0] from instruction register
// zero          in   1  ALU zero flag
// PCWrite       out  1  PC register enable
// AdrSrc        out  1  memory address select: 0 PC, 1 ALUOut
// MemWrite      out  1  data memory write strobe
// IRWrite       out  1  instruction/OldPC register enable
// ResultSrc     out  2  00 ALUOut, 01 Data, 10 ALUResult
// ALUSrcA       out  2  00 PC, 01 OldPC, 10 rs1 register
// ALUSrcB       out  2  00 rs2 register, 01 ImmExt, 10 constant 4
// ALUOp         out  2  to ALU decoder
// ImmSrc        out  2  00 I/lw, 01 S, 10 B, 11 J (decoded from op, combinational)
// RegWrite      out  1  register file write enable
// state_o       out  4  current state encoding (debug/coverage)
// instr_done_o  out  1  one-cycle pulse in final cycle of each instruction
// illegal_o     out  1  one-cycle pulse in DECODE for an unsupported op
// BEHAVIOUR
// - States/encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6,
//   EXECI 7, ALUWB 8, BEQ 9, JAL 10. Codes 11..15 unreachable; if entered, next state FETCH.
// - Moore outputs from state; ImmSrc from op only; PCWrite = PCUpdate | (Branch & zero).
// - Unlisted outputs are 0. ALUOp is 00 except in EXECR, EXECI (10) and BEQ (01).
// - FETCH:  AdrSrc0, IRWrite, ALUSrcA00, ALUSrcB10, ResultSrc10, PCUpdate -> DECODE
// - DECODE: ALUSrcA01, ALUSrcB01 (branch target). Next: lw/sw->MEMADR, 0110011->EXECR,
//   0010011->EXECI, 1100011->BEQ, 1101111->JAL, else illegal_o=1 -> FETCH (no writes).
// - MEMADR: ALUSrcA10, ALUSrcB01 -> MEMREAD (lw) / MEMWRITE (sw)
// - MEMREAD: AdrSrc1 -> MEMWB.   MEMWB: ResultSrc01, RegWrite -> FETCH
// - MEMWRITE: AdrSrc1, MemWrite -> FETCH
// - EXECR: ALUSrcA10, ALUSrcB00 -> ALUWB.   EXECI: ALUSrcA10, ALUSrcB01 -> ALUWB
// - ALUWB: ResultSrc00, RegWrite -> FETCH
// - BEQ: ALUSrcA10, ALUSrcB00, ResultSrc00, Branch -> FETCH
// - JAL: ALUSrcA01, ALUSrcB10, ResultSrc00, PCUpdate -> ALUWB (writes PC+4 to rd)
// - Latency (MEM_WAIT_CYCLES=0): lw 5, sw 4, R/I 4, beq 3, jal 4, illegal 2 cycles.
// - Wait states: 4-bit counter cleared on entry to FETCH, MEMREAD and MEMWRITE; each lasts
//   MEM_WAIT_CYCLES+1 cycles. Selects are held for the whole state. IRWrite, PCUpdate and
//   MemWrite assert only in the final cycle. The state advances only when the counter reaches
//   MEM_WAIT_CYCLES.
// - instr_done_o=1 in MEMWB, the last MEMWRITE cycle, ALUWB, BEQ and the illegal DECODE cycle.
// - Reset: state->FETCH and counter->0 immediately. While rst=1, PCWrite, MemWrite, IRWrite,
//   RegWrite, instr_done_o and illegal_o are forced 0. Other outputs show FETCH values.
// - Reset mid-instruction aborts it; first post-reset cycle is a full FETCH; no partial writes.
// - zero is sampled only in BEQ; it is ignored in every other state.
// TESTING
// - rst pulse mid-MEMREAD -> state_o=0 while rst high, all strobes 0; fetch restarts on release.
// - lw (op=0000011) -> state_o 0,1,2,3,4; RegWrite=1 only in cycle 5 with ResultSrc=01.
// - sw (op=0100011), MEM_WAIT_CYCLES=2 -> FETCH 3 cycles, IRWrite only in 3rd.
//   MEMWRITE 3 cycles, MemWrite only in last; instr_done_o in that cycle.
// - R-type (0110011) -> EXECR: ALUOp=10, ALUSrcB=00; then ALUWB: RegWrite=1.
//   I-type (0010011) -> EXECI: ALUSrcB=01.
// - beq with zero=1 -> PCWrite=1 in BEQ (cycle 3) with ALUOp=01; zero=0 -> PCWrite=0.
//   jal -> JAL then ALUWB, ImmSrc=11.
// - op=1111111 -> illegal_o pulse in DECODE, no RegWrite/MemWrite, next state FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32I main controller.
// Steps each instruction through FETCH/DECODE/... states and drives the
// datapath enables and mux selects. FETCH, MEMREAD and MEMWRITE can be
// stretched by MEM_WAIT_CYCLES extra cycles for slow memories.
module multicycle_controller #(
  parameter int MEM_WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [3:0] state_o,
  output logic       instr_done_o,
  output logic       illegal_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_CYCLES);

  logic [3:0] r_state;
  logic [3:0] r_cnt;
  logic [3:0] w_state_next;
  logic       w_wait_state;
  logic       w_last;
  logic       w_legal_op;
  logic       w_pc_update;
  logic       w_branch;

  // Only the memory-facing states stretch; all others finish in one cycle.
  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                        (r_state == S_MEMWRITE);
  assign w_last       = !w_wait_state || (r_cnt == WAIT_LAST);
  assign w_legal_op   = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                        (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
  assign state_o      = r_state;

  // State register; reset drops straight back into FETCH, aborting any instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Wait counter restarts on every state change so each wait state starts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (w_state_next != r_state) begin
      r_cnt <= 4'd0;
    end else if (w_wait_state && !w_last) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Next-state decode; a stretched state holds until its final cycle.
  always_comb begin
    w_state_next = r_state;
    if (w_last) begin
      case (r_state)
        S_FETCH:    w_state_next = S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: w_state_next = S_MEMADR;
            OP_R:         w_state_next = S_EXECR;
            OP_I:         w_state_next = S_EXECI;
            OP_BEQ:       w_state_next = S_BEQ;
            OP_JAL:       w_state_next = S_JAL;
            default:      w_state_next = S_FETCH;
          endcase
        end
        S_MEMADR:   w_state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  w_state_next = S_MEMWB;
        S_MEMWB:    w_state_next = S_FETCH;
        S_MEMWRITE: w_state_next = S_FETCH;
        S_EXECR:    w_state_next = S_ALUWB;
        S_EXECI:    w_state_next = S_ALUWB;
        S_ALUWB:    w_state_next = S_FETCH;
        S_BEQ:      w_state_next = S_FETCH;
        S_JAL:      w_state_next = S_ALUWB;
        default:    w_state_next = S_FETCH;
      endcase
    end
  end

  // Moore outputs; write strobes fire only in the last cycle and are masked during reset.
  always_comb begin
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    AdrSrc       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    RegWrite     = 1'b0;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    case (r_state)
      S_FETCH: begin
        IRWrite     = w_last;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        w_pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b01;
        illegal_o    = !w_legal_op;
        instr_done_o = !w_legal_op;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc    = 2'b01;
        RegWrite     = 1'b1;
        instr_done_o = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc       = 1'b1;
        MemWrite     = w_last;
        instr_done_o = w_last;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite     = 1'b1;
        instr_done_o = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA      = 2'b10;
        ALUOp        = 2'b01;
        w_branch     = 1'b1;
        instr_done_o = 1'b1;
      end
      S_JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pc_update = 1'b1;
      end
      default: ;
    endcase
    PCWrite = (w_pc_update & w_last) | (w_branch & zero);
    if (rst) begin
      PCWrite      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      instr_done_o = 1'b0;
      illegal_o    = 1'b0;
    end
  end

  // Immediate format follows the opcode directly, independent of state.
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus pushes the expected
// output vector for each cycle, a negedge monitor pops and compares.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic       zero;

  logic       pcw0, adr0, mw0, irw0, rw0, done0, ill0;
  logic [1:0] rs0, asa0, asb0, aop0, imm0;
  logic [3:0] st0;
  logic       pcw2, adr2, mw2, irw2, rw2, done2, ill2;
  logic [1:0] rs2, asa2, asb2, aop2, imm2;
  logic [3:0] st2;

  multicycle_controller #(.MEM_WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .op(op), .zero(zero),
    .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0),
    .ResultSrc(rs0), .ALUSrcA(asa0), .ALUSrcB(asb0), .ALUOp(aop0),
    .ImmSrc(imm0), .RegWrite(rw0), .state_o(st0),
    .instr_done_o(done0), .illegal_o(ill0)
  );

  multicycle_controller #(.MEM_WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .op(op), .zero(zero),
    .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(mw2), .IRWrite(irw2),
    .ResultSrc(rs2), .ALUSrcA(asa2), .ALUSrcB(asb2), .ALUOp(aop2),
    .ImmSrc(imm2), .RegWrite(rw2), .state_o(st2),
    .instr_done_o(done2), .illegal_o(ill2)
  );

  logic [20:0] act0, act2;
  assign act0 = {pcw0, adr0, mw0, irw0, rs0, asa0, asb0, aop0, imm0, rw0, st0, done0, ill0};
  assign act2 = {pcw2, adr2, mw2, irw2, rs2, asa2, asb2, aop2, imm2, rw2, st2, done2, ill2};

  logic [20:0] exp_q[$];
  bit          tag_q[$];
  string       name_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [20:0] m_exp, m_act;
  bit          m_tag;
  string       m_name;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack one expected output vector (multi-bit fields given as decimals).
  function automatic logic [20:0] ev(int pcw, int adr, int mw, int irw, int rs,
                                     int asa, int asb, int aop, int imm, int rw,
                                     int st, int done, int ill);
    return {1'(pcw), 1'(adr), 1'(mw), 1'(irw), 2'(rs), 2'(asa), 2'(asb),
            2'(aop), 2'(imm), 1'(rw), 4'(st), 1'(done), 1'(ill)};
  endfunction

  // Queue the expectation for the current cycle, then move to the next cycle.
  task automatic cyc(input logic [20:0] e, input bit d2, input string nm);
    exp_q.push_back(e);
    tag_q.push_back(d2);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the selected DUT against the oldest expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_exp  = exp_q.pop_front();
      m_tag  = tag_q.pop_front();
      m_name = name_q.pop_front();
      m_act  = m_tag ? act2 : act0;
      n_checks++;
      if (m_act !== m_exp) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", m_name, m_act, m_exp);
      end else begin
        $display("ok   %s: %b", m_name, m_act);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    op   = 7'b0000011;
    zero = 1'b0;
    @(posedge clk);
    #1;
    // reset state on both instances
    cyc(ev(0,0,0,0,2,0,2,0,0,0,0,0,0), 0, "reset_dut0");
    cyc(ev(0,0,0,0,2,0,2,0,0,0,0,0,0), 1, "reset_dut2");
    rst = 1'b0;

    // lw aborted by reset entering MEMREAD
    cyc(ev(1,0,0,1,2,0,2,0,0,0,0,0,0), 0, "lwA_fetch");
    cyc(ev(0,0,0,0,0,1,1,0,0,0,1,0,0), 0, "lwA_decode");
    zero = 1'b1;
    cyc(ev(0,0,0,0,0,2,1,0,0,0,2,0,0), 0, "lwA_memadr");
    rst = 1'b1;
    cyc(ev(0,0,0,0,2,0,2,0,0,0,0,0,0), 0, "rst_mid_memread");
    cyc(ev(0,0,0,0,2,0,2,0,0,0,0,0,0), 0, "rst_hold");
    rst = 1'b0;

    // lw complete, zero held high to show it is ignored
    cyc(ev(1,0,0,1,2,0,2,0,0,0,0,0,0), 0, "lw_fetch");
    cyc(ev(0,0,0,0,0,1,1,0,0,0,1,0,0), 0, "lw_decode");
    cyc(ev(0,0,0,0,0,2,1,0,0,0,2,0,0), 0, "lw_memadr");
    cyc(ev(0,1,0,0,0,0,0,0,0,0,3,0,0), 0, "lw_memread");
    cyc(ev(0,0,0,0,1,0,0,0,0,1,4,1,0), 0, "lw_memwb");

    // sw without wait states
    op = 7'b0100011; zero = 1'b0;
    cyc(ev(1,0,0,1,2,0,2,0,1,0,0,0,0), 0, "sw_fetch");
    cyc(ev(0,0,0,0,0,1,1,0,1,0,1,0,0), 0, "sw_decode");
    cyc(ev(0,0,0,0,0,2,1,0,1,0,2,0,0), 0, "sw_memadr");
    cyc(ev(0,1,1,0,0,0,0,0,1,0,5,1,0), 0, "sw_memwrite");

    // R-type
    op = 7'b0110011;
    cyc(ev(1,0,0,1,2,0,2,0,0,0,0,0,0), 0, "r_fetch");
    cyc(ev(0,0,0,0,0,1,1,0,0,0,1,0,0), 0, "r_decode");
    cyc(ev(0,0,0,0,0,2,0,2,0,0,6,0,0), 0, "r_execr");
    cyc(ev(0,0,0,0,0,0,0,0,0,1,8,1,0), 0, "r_aluwb");

    // I-type ALU
    op = 7'b0010011;
    cyc(ev(1,0,0,1,2,0,2,0,0,0,0,0,0), 0, "i_fetch");
    cyc(ev(0,0,0,0,0,1,1,0,0,0,1,0,0), 0, "i_decode");
    cyc(ev(0,0,0,0,0,2,1,2,0,0,7,0,0), 0, "i_execi");
    cyc(ev(0,0,0,0,0,0,0,0,0,1,8,1,0), 0, "i_aluwb");

    // beq taken
    op = 7'b1100011; zero = 1'b1;
    cyc(ev(1,0,0,1,2,0,2,0,2,0,0,0,0), 0, "beqT_fetch");
    cyc(ev(0,0,0,0,0,1,1,0,2,0,1,0,0), 0, "beqT_decode");
    cyc(ev(1,0,0,0,0,2,0,1,2,0,9,1,0), 0, "beqT_beq");

    // beq not taken
    zero = 1'b0;
    cyc(ev(1,0,0,1,2,0,2,0,2,0,0,0,0), 0, "beqN_fetch");
    cyc(ev(0,0,0,0,0,1,1,0,2,0,1,0,0), 0, "beqN_decode");
    cyc(ev(0,0,0,0,0,2,0,1,2,0,9,1,0), 0, "beqN_beq");

    // jal
    op = 7'b1101111; zero = 1'b1;
    cyc(ev(1,0,0,1,2,0,2,0,3,0,0,0,0), 0, "jal_fetch");
    cyc(ev(0,0,0,0,0,1,1,0,3,0,1,0,0), 0, "jal_decode");
    cyc(ev(1,0,0,0,0,1,2,0,3,0,10,0,0), 0, "jal_jal");
    cyc(ev(0,0,0,0,0,0,0,0,3,1,8,1,0), 0, "jal_aluwb");

    // unsupported opcode
    op = 7'b1111111; zero = 1'b0;
    cyc(ev(1,0,0,1,2,0,2,0,0,0,0,0,0), 0, "ill_fetch");
    cyc(ev(0,0,0,0,0,1,1,0,0,0,1,1,1), 0, "ill_decode");
    op = 7'b0000011;
    cyc(ev(1,0,0,1,2,0,2,0,0,0,0,0,0), 0, "ill_next_fetch");

    // sw with two wait states on the second instance
    rst = 1'b1;
    cyc(ev(0,0,0,0,2,0,2,0,0,0,0,0,0), 1, "w2_reset");
    rst = 1'b0; op = 7'b0100011;
    cyc(ev(0,0,0,0,2,0,2,0,1,0,0,0,0), 1, "w2_fetch_c1");
    cyc(ev(0,0,0,0,2,0,2,0,1,0,0,0,0), 1, "w2_fetch_c2");
    cyc(ev(1,0,0,1,2,0,2,0,1,0,0,0,0), 1, "w2_fetch_c3");
    cyc(ev(0,0,0,0,0,1,1,0,1,0,1,0,0), 1, "w2_decode");
    cyc(ev(0,0,0,0,0,2,1,0,1,0,2,0,0), 1, "w2_memadr");
    cyc(ev(0,1,0,0,0,0,0,0,1,0,5,0,0), 1, "w2_memwrite_c1");
    cyc(ev(0,1,0,0,0,0,0,0,1,0,5,0,0), 1, "w2_memwrite_c2");
    cyc(ev(0,1,1,0,0,0,0,0,1,0,5,1,0), 1, "w2_memwrite_c3");
    cyc(ev(0,0,0,0,2,0,2,0,1,0,0,0,0), 1, "w2_next_fetch");

    // let the monitor drain, bounded
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
